// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchronised serial input, 16x oversampled centre sampling,
// DBIT data bits LSB-first, optional parity, one stop bit; one-clk done pulse with error flags.
module uart_receiver #(
  parameter int unsigned DBIT = 8,
  parameter int unsigned OVS  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            parity_en,
  input  logic            parity_mode,
  output logic [DBIT-1:0] data_rx,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam int unsigned SW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] sh_q;
  logic            p_q;
  logic            rx_meta_q;
  logic            rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      sh_q         <= '0;
      p_q          <= 1'b0;
      data_rx      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Start-edge detection runs every clk so back-to-back frames lose nothing.
          if (!rx_s_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_MID) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_END) begin
              sh_q <= {rx_s_q, sh_q[DBIT-1:1]};
              s_q  <= '0;
              if (n_q == N_LAST) begin
                state_q <= parity_en ? PARITY : STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s_q == S_END) begin
              p_q     <= rx_s_q;
              s_q     <= '0;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_END) begin
              state_q      <= IDLE;
              s_q          <= '0;
              data_rx      <= sh_q;
              frame_err    <= ~rx_s_q;
              parity_err   <= parity_en & (p_q != (parity_mode ? ^sh_q : ~^sh_q));
              rx_done_tick <= 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: s_tick every 4 clk, so one bit period is 64 clk.
module tb_uart_receiver;

  localparam int unsigned BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_mode = 1'b0;
  logic [7:0] data_rx;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  logic [9:0]  rec_q[$];
  logic [1:0]  tick_div = '0;

  uart_receiver #(.DBIT(8), .OVS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .parity_en    (parity_en),
    .parity_mode  (parity_mode),
    .data_rx      (data_rx),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_div = tick_div + 2'd1;
    s_tick   = (tick_div == 2'd0);
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt = done_cnt + 1;
      rec_q.push_back({frame_err, parity_err, data_rx});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int unsigned clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop_bit, input int unsigned stop_clks);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    if (par_on) drive(par_bit, BIT);
    drive(stop_bit, stop_clks);
    rx = 1'b1;
  endtask

  initial begin
    int unsigned d0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_data", 32'(data_rx), 32'h0);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: 0x55, no parity
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    #1;
    check("t1_done_cnt", done_cnt - d0, 32'd1);
    check("t1_data", 32'(data_rx), 32'h55);
    check("t1_perr", 32'(parity_err), 32'h0);
    check("t1_ferr", 32'(frame_err), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);

    // 2: even parity on 0xA3 (four ones -> parity bit 0)
    parity_en = 1'b1;
    parity_mode = 1'b1;
    d0 = done_cnt;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, BIT);
    repeat (BIT) @(negedge clk);
    #1;
    check("t2a_done_cnt", done_cnt - d0, 32'd1);
    check("t2a_data", 32'(data_rx), 32'hA3);
    check("t2a_perr", 32'(parity_err), 32'h0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, BIT);
    repeat (BIT) @(negedge clk);
    #1;
    check("t2b_done_cnt", done_cnt - d0, 32'd2);
    check("t2b_data", 32'(data_rx), 32'hA3);
    check("t2b_perr", 32'(parity_err), 32'h1);
    check("t2b_ferr", 32'(frame_err), 32'h0);

    // 3: stop bit low, released before the restarted START mid-sample
    parity_en = 1'b0;
    d0 = done_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, (3 * BIT) / 4);
    #1;
    check("t3_done_cnt", done_cnt - d0, 32'd1);
    check("t3_data", 32'(data_rx), 32'h0F);
    check("t3_ferr", 32'(frame_err), 32'h1);
    check("t3_perr", 32'(parity_err), 32'h0);
    repeat (2 * BIT) @(negedge clk);
    #1;
    check("t3_no_extra_done", done_cnt - d0, 32'd1);
    check("t3_busy", 32'(busy), 32'h0);

    // 4: 4-tick low glitch
    d0 = done_cnt;
    drive(1'b0, 8);
    check("t4_busy_in_start", 32'(busy), 32'h1);
    drive(1'b0, 8);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    #1;
    check("t4_no_done", done_cnt - d0, 32'd0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_data_held", 32'(data_rx), 32'h0F);

    // 5: reset during DATA bit 3, then a clean 0xC4
    drive(1'b0, BIT);
    drive(1'b0, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT / 2);
    #2;
    check("t5_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_data", 32'(data_rx), 32'h0);
    check("t5_rst_ferr", 32'(frame_err), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_done", 32'(rx_done_tick), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'hC4, 1'b0, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    #1;
    check("t5_done_cnt", done_cnt - d0, 32'd1);
    check("t5_data", 32'(data_rx), 32'hC4);
    check("t5_ferr", 32'(frame_err), 32'h0);

    // 6: back-to-back, odd parity: 0x00->1, 0xFF->1, 0x81->1
    parity_en = 1'b1;
    parity_mode = 1'b0;
    rec_q.delete();
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, BIT);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    #1;
    check("t6_frames", 32'(rec_q.size()), 32'd3);
    if (rec_q.size() == 3) begin
      check("t6_f0", 32'(rec_q[0]), 32'h000);
      check("t6_f1", 32'(rec_q[1]), 32'h0FF);
      check("t6_f2", 32'(rec_q[2]), 32'h081);
    end
    check("t6_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
